mem_burst_reader: RTL

MEM_BURST_READER -- requirements
Module: mem_burst_reader

---
 rtl/mem_burst_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: walks a 1-bit wide memory and packs consecutive bits,
// LSB first, into WORD_WIDTH-bit words. The words are handed to a consumer
// over a valid/ready handshake, and done pulses once at the end of a burst.
module mem_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_din,
  input  logic                  mem_dout,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // The bit counter needs at least one bit, even for single-bit words.
  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  load;
  logic                  accept;
  logic                  last_bit;
  logic                  last_word;

  // State register; reset drops straight back to IDLE, aborting any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the load/accept strobes that steer the datapath.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    accept     = 1'b0;
    last_bit   = (bit_cnt == LAST_BIT);
    last_word  = (remaining == ADDR_WIDTH'(1));
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            load       = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = FINISH;
          end
        end
      end
      FETCH: begin
        if (last_bit) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          accept     = 1'b1;
          next_state = last_word ? FINISH : FETCH;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: the address and bit counter advance only while fetching. Each
  // new bit enters at the top and moves down, so after WORD_WIDTH shifts the
  // first bit fetched sits in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      shift_reg <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
    end else begin
      if (load) begin
        mem_addr  <= base_addr;
        remaining <= num_words;
      end
      if (state == FETCH) begin
        shift_reg <= (shift_reg >> 1) | (WORD_WIDTH'(mem_dout) << (WORD_WIDTH - 1));
        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
        bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
      if (accept) begin
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end

  assign word_data  = shift_reg;
  assign word_valid = (state == HOLD);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign mem_we     = 1'b0;
  assign mem_din    = 1'b0;

endmodule
